prog_loader: RTL and testbench

Program loader and run sequencer for the SAP-1 computer. Before execution, it accepts a stream of program bytes over a valid/ready handshake and writes them into the 16×8 program RAM, holding the CPU off the bus. It then releases the CPU and watches the controller's halt line. It sits between the external program source, the RAM write port and the CPU run/enable input.

---
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader -- program loader and run sequencer for the SAP-1 computer.
//
// Streams program words from a valid/ready source into the 2^ADDR_W x DATA_W
// program RAM while the CPU is held off the bus. When the load finishes, it
// releases the CPU and waits for the controller's halt line or a reload
// request.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-low reset
//   START     begin a load (honoured in IDLE and RUN only)
//   IN_VALID  stream word present
//   IN_DATA   stream word
//   IN_LAST   final program word (qualified by IN_VALID)
//   IN_READY  loader accepts a word this cycle
//   MEM_WE    RAM write strobe, one cycle per word
//   MEM_ADDR  RAM write address
//   MEM_DATA  RAM write data
//   HLT       halt from the SAP-1 controller
//   CPU_RUN   1 = CPU enabled
//   BUSY      1 while loading (LOAD or WRITE)
//   DONE      one-cycle pulse when a load completes
//   OVF       sticky: RAM filled without IN_LAST
//   WCOUNT    words written in the current/last load
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  input  logic              HLT,
  output logic              CPU_RUN,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [ADDR_W:0]   WCOUNT
);

  localparam logic [ADDR_W-1:0] ADDR_TOP   = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WCOUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WCOUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FINISH,
    S_RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;   // address of the word being loaded
  logic              last;   // latched IN_LAST of the word in WRITE
  logic              accept;

  // IN_READY is registered and equals (state == S_LOAD), so this is the
  // handshake without any input-to-output path.
  assign accept = IN_VALID && IN_READY;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = S_LOAD;
      S_LOAD:   if (accept) state_next = S_WRITE;
      S_WRITE:  state_next = (last || addr == ADDR_TOP) ? S_FINISH : S_LOAD;
      S_FINISH: state_next = S_RUN;
      S_RUN: begin
        // Halt has priority over a simultaneous reload request.
        if (HLT)        state_next = S_IDLE;
        else if (START) state_next = S_LOAD;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      addr     <= '0;
      last     <= 1'b0;
      IN_READY <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      CPU_RUN  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVF      <= 1'b0;
      WCOUNT   <= '0;
    end else begin
      state <= state_next;

      // Outputs are registered from the next state so they line up with it.
      IN_READY <= (state_next == S_LOAD);
      MEM_WE   <= (state_next == S_WRITE);
      BUSY     <= (state_next == S_LOAD) || (state_next == S_WRITE);
      DONE     <= (state_next == S_FINISH);
      CPU_RUN  <= (state_next == S_RUN);

      // A fresh load (from IDLE or a reload from RUN) restarts everything.
      if ((state == S_IDLE || state == S_RUN) && state_next == S_LOAD) begin
        addr   <= '0;
        WCOUNT <= '0;
        OVF    <= 1'b0;
      end

      if (accept) begin
        MEM_ADDR <= addr;
        MEM_DATA <= IN_DATA;
        last     <= IN_LAST;
      end

      if (state == S_WRITE) begin
        if (WCOUNT != WCOUNT_MAX) WCOUNT <= WCOUNT + WCOUNT_ONE;
        if (!last) begin
          // Top address written without LAST: stop and flag overflow
          // instead of wrapping onto address 0.
          if (addr == ADDR_TOP) OVF <= 1'b1;
          else                  addr <= addr + ADDR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- randomized self-checking bench for prog_loader.
// A transaction-level model predicts, per load, the list of RAM writes, the
// final word count, the overflow flag and the completion latency; a monitor
// records every MEM_WE and mirrors it into a bench-side RAM image.
module tb_prog_loader;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          hlt;
  logic          cpu_run;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW:0]   wcount;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst), .START(start),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_LAST(in_last), .IN_READY(in_ready),
    .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data),
    .HLT(hlt), .CPU_RUN(cpu_run), .BUSY(busy), .DONE(done), .OVF(ovf), .WCOUNT(wcount)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [DW-1:0] words   [20];
  logic [DW-1:0] dut_ram [DEPTH];
  logic [DW-1:0] exp_ram [DEPTH];
  int            wr_addr_q[$];
  int            wr_data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record writes, mirror the RAM, and DONE never overlaps CPU_RUN.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_data));
      dut_ram[mem_addr] = mem_data;
    end
    if (done) check("done_run_excl", cpu_run, 0);
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"},    mem_we,   0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_data"},  mem_data, 0);
    check({tag, "_run"},   cpu_run,  0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_done"},  done,     0);
    check({tag, "_ovf"},   ovf,      0);
    check({tag, "_wcnt"},  wcount,   0);
  endtask

  // One program load of n words (LAST on word n when use_last). Without
  // LAST the loader must stop after DEPTH words and flag overflow.
  task automatic do_load(input int n, input bit use_last, input bit gappy);
    int k_exp;
    int idx;
    int budget;
    int load_cyc;
    int nw;
    bit ovf_exp;
    k_exp   = use_last ? n : DEPTH;
    ovf_exp = !use_last;
    idx     = 0;
    budget  = 0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start",  busy,     1);
    check("ready_after_start", in_ready, 1);
    check("run_off_in_load",   cpu_run,  0);
    check("ovf_cleared",       ovf,      0);
    check("wcount_cleared",    wcount,   0);
    load_cyc = cyc;
    while (!done && budget < 200) begin
      if (idx < k_exp) begin
        in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = words[idx];
        in_last  = in_valid ? (use_last && idx == n - 1) : 1'($urandom_range(0, 1));
      end else begin
        // Surplus word: must never be taken after LAST or overflow.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b0;
      end
      start = ($urandom_range(0, 3) == 0);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    check("done_seen",      done, 1);
    check("words_accepted", idx,  k_exp);
    if (!gappy) check("done_latency", cyc - load_cyc, 2 * k_exp);
    @(negedge clk);
    check("run_after_done", cpu_run,  1);
    check("done_one_cycle", done,     0);
    check("busy_in_run",    busy,     0);
    check("ready_in_run",   in_ready, 0);
    check("wcount_final",   wcount,   k_exp);
    check("ovf_final",      ovf,      ovf_exp);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    nw = wr_addr_q.size();
    check("write_count", nw, k_exp);
    for (int i = 0; i < nw && i < k_exp; i++) begin
      check("wr_addr", wr_addr_q[i], i);
      check("wr_data", wr_data_q[i], int'(words[i]));
    end
    for (int i = 0; i < k_exp; i++) exp_ram[i] = words[i];
    $display("load n=%0d last=%0d gappy=%0d -> writes=%0d wcount=%0d ovf=%0d",
             n, use_last, gappy, nw, wcount, ovf);
  endtask

  // From RUN: assert HLT (optionally with START); CPU must stop, no load.
  task automatic do_halt(input bit with_start);
    @(negedge clk);
    hlt   = 1'b1;
    start = with_start;
    @(negedge clk);
    hlt   = 1'b0;
    start = 1'b0;
    check("halt_run_off", cpu_run,  0);
    check("halt_busy",    busy,     0);
    check("halt_ready",   in_ready, 0);
    @(negedge clk);
    check("halt_stays_idle", busy,    0);
    check("halt_stays_off",  cpu_run, 0);
    $display("halt with_start=%0d -> cpu_run=%0d busy=%0d", with_start, cpu_run, busy);
  endtask

  // Reset asserted while the 2nd word is being written.
  task automatic do_reset_midload();
    int idx;
    int budget;
    idx    = 0;
    budget = 0;
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b0;
    while (!(mem_we && mem_addr == 4'd1) && budget < 50) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      in_last  = 1'b0;
      if (in_ready) idx++;
      @(negedge clk);
      budget++;
    end
    check("reset_point_reached", budget < 50, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midload_rst");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("midload_writes", wr_addr_q.size(), 2);
    check("midload_wcount", wcount, 0);
    check("midload_busy",   busy,   0);
    exp_ram[0] = words[0];
    exp_ram[1] = words[1];
    $display("reset mid-load -> writes=%0d wcount=%0d", wr_addr_q.size(), wcount);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    hlt      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dut_ram[i] = '0;
      exp_ram[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // Directed: three-word program, valid held high.
    words[0] = 8'h1E;
    words[1] = 8'h2F;
    words[2] = 8'hE0;
    do_load(3, 1'b1, 1'b0);
    do_halt(1'b0);

    // Randomized loads, with random halts or reloads from RUN.
    for (int t = 0; t < 10; t++) begin
      int  n;
      bit  use_last;
      bit  gappy;
      n        = $urandom_range(1, DEPTH);
      use_last = ($urandom_range(0, 3) != 0);
      gappy    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
      do_load(n, use_last, gappy);
      if ($urandom_range(0, 1) == 1) do_halt(1'($urandom_range(0, 1)));
    end

    // Boundaries: overflow, then LAST exactly on the top address.
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    do_load(DEPTH, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    do_load(DEPTH, 1'b1, 1'b1);
    do_halt(1'b1);

    do_reset_midload();

    for (int i = 0; i < DEPTH; i++) check("ram_image", dut_ram[i], exp_ram[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
